encode_instruction: RTL and testbench
=====================================

// Module: encode_instruction
// PURPOSE
// - Inverse of immediate generation: packs decoded fields (format, opcode, registers, functs, 32-bit immediate) into a RV32I instruction word.
// - Scatters immediate bits into R/I/S/B/U/J layouts; range- and alignment-checks the immediate.
// - Streams results with sequential write addresses to the instruction-memory loader (test-program builder, self-check bench).
// - Two-stage pipeline with valid/ready on both sides.
// PARAMETERS
// - DEPTH        256   instruction-memory words; out_address wraps at DEPTH-1 -> 0
// - ADDR_WIDTH   8     width of out_address; DEPTH <= 2**ADDR_WIDTH
// - COUNT_WIDTH  8     width of error_count (saturating)
// PORTS
// - clock        in   1   rising-edge clock (single clock domain)
// - reset        in   1   asynchronous, active-high
// - in_valid     in   1   request fields valid
// - in_ready     out  1   block accepts request this cycle
// - in_format    in   3   0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
// - in_opcode    in   7   placed in inst[6:0] unchanged
// - in_rd        in   5   inst[11:7] (R,I,U,J)
// - in_rs1       in   5   inst[19:15] (R,I,S,B)
// - in_rs2       in   5   inst[24:20] (R,S,B)
// - in_funct3    in   3   inst[14:12] (R,I,S,B)
// - in_funct7    in   7   inst[31:25] (R only)
// - in_immediate in   32  signed byte offset / value (ignored for R)
// - out_valid    out  1   out_instruction/out_address/out_error valid
// - out_ready    in   1   consumer accepts output this cycle
// - out_instruction out 32 packed word
// - out_address  out  ADDR_WIDTH word address of this instruction
// - out_error    out  1   request failed checks; word is NOP
// - error_count  out  COUNT_WIDTH errored requests since reset, saturates at all-ones
// BEHAVIOUR
// - Reset (async, any time): both stage valids 0; out_valid=0, out_instruction=0, out_address=0, out_error=0, error_count=0. In-flight requests discarded; no partial output.
// - Handshake: transfer when valid&&ready on the same edge. in_ready = !s1_valid || s2_advance; s2_advance = !out_valid || out_ready. in_ready never depends on in_valid.
// - Stage 1 (check+pack) registers word and error. Stage 2 (output) registers word, error, address.
// - Latency 2 cycles accept -> out_valid with out_ready high; throughput 1/cycle.
// - Backpressure: out_ready low holds all outputs stable; stage 1 fills, then in_ready drops. No loss, duplication or reordering.
// - Packing (unused-field inputs ignored):
//   R: {funct7,rs2,rs1,funct3,rd,opcode}
//   I: {imm[11:0],rs1,funct3,rd,opcode}
//   S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
//   B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
//   U: {imm[31:12],rd,opcode}
//   J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
// - Checks (any failure -> error, word = 32'h00000013 NOP):
//   I,S: imm[31:11] all equal. B: imm[31:12] all equal and imm[0]==0.
//   J: imm[31:20] all equal and imm[0]==0. U: imm[11:0]==0. Format 6/7 always error.
// - out_address: address of current output; advances by 1 on each output transfer (errored words included), wraps DEPTH-1 -> 0. First output after reset = 0.
// - error_count: +1 when an errored word transfers out; holds at max.
// - Simultaneous input and output transfer in one cycle supported with no bubble.
// TESTING
// - I: opcode=0010011 rd=1 rs1=0 f3=0 imm=5 -> 0x00500093, out_address=0, out_error=0, 2 cycles after accept.
// - B/J: beq opcode=1100011 rs1=rs2=0 imm=-8 -> 0xFE000CE3; jal opcode=1101111 rd=1 imm=0x800 -> 0x001000EF; R add rd=3 rs1=1 rs2=2 -> 0x002081B3; U lui rd=5 imm=0x12345000 -> 0x123452B7.
// - Errors: I imm=4096; B imm=6 (odd/2 fine, test imm=7); U imm=0x00000001; format=6 -> each 0x00000013 with out_error=1, error_count 0->4.
// - Backpressure: out_ready=0 for 6 cycles, offer 4 back-to-back -> in_ready low after 2 accepted, outputs held; release -> all 4 in order, addresses 0..3.
// - Wrap: DEPTH=4, 6 transfers -> addresses 0,1,2,3,0,1.
// - Reset mid-stream: assert reset with both stages full -> out_valid=0 immediately (async); next output address 0, error_count 0.

Source files
------------

// File: rtl/encode_instruction_if.sv
// Bundle between the encoder, its field-level requester and the
// instruction-memory loader that consumes packed words with their addresses.
interface encode_instruction_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2:0]             in_format;
  logic [6:0]             in_opcode;
  logic [4:0]             in_rd;
  logic [4:0]             in_rs1;
  logic [4:0]             in_rs2;
  logic [2:0]             in_funct3;
  logic [6:0]             in_funct7;
  logic [31:0]            in_immediate;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_instruction;
  logic [ADDR_WIDTH-1:0]  out_address;
  logic                   out_error;
  logic [COUNT_WIDTH-1:0] error_count;

  modport master (
    output in_valid, in_format, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_immediate, out_ready,
    input  in_ready, out_valid, out_instruction, out_address, out_error,
           error_count
  );

  modport slave (
    input  in_valid, in_format, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_immediate, out_ready,
    output in_ready, out_valid, out_instruction, out_address, out_error,
           error_count
  );
endinterface

// File: rtl/encode_instruction.sv
// RV32I instruction encoder: packs decoded fields into a word, range-checks the
// immediate, and streams words with sequential addresses through a 2-stage pipe.
module encode_instruction #(
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input logic                 clock,
  input logic                 reset,
  encode_instruction_if.slave bus
);
  localparam logic [31:0]           NOP       = 32'h0000_0013;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic                   s1Valid_q, s1Valid_d;
  logic                   s1Err_q, s1Err_d;
  logic [31:0]            s1Word_q, s1Word_d;
  logic                   s2Valid_q, s2Valid_d;
  logic                   s2Err_q, s2Err_d;
  logic [31:0]            s2Word_q, s2Word_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] errCount_q, errCount_d;

  logic        s2Advance;
  logic        inReady;
  logic        outXfer;
  logic [31:0] imm;
  logic [31:0] packedWord;
  logic        packedErr;
  logic        immFits12;
  logic        immFits13;
  logic        immFits21;

  assign imm       = bus.in_immediate;
  // Sign-extension checks: every bit above the field's top bit must copy it.
  assign immFits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign immFits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign immFits21 = (&imm[31:20]) | ~(|imm[31:20]);

  assign s2Advance = !s2Valid_q || bus.out_ready;
  assign inReady   = !s1Valid_q || s2Advance;
  assign outXfer   = s2Valid_q && bus.out_ready;

  always_comb begin
    packedWord = NOP;
    packedErr  = 1'b0;
    case (bus.in_format)
      3'd0: packedWord = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          bus.in_rd, bus.in_opcode};
      3'd1: begin
        packedWord = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        packedErr  = !immFits12;
      end
      3'd2: begin
        packedWord = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0],
                      bus.in_opcode};
        packedErr  = !immFits12;
      end
      3'd3: begin
        packedWord = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                      imm[4:1], imm[11], bus.in_opcode};
        packedErr  = !immFits13 || imm[0];
      end
      3'd4: begin
        packedWord = {imm[31:12], bus.in_rd, bus.in_opcode};
        packedErr  = |imm[11:0];
      end
      3'd5: begin
        packedWord = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
        packedErr  = !immFits21 || imm[0];
      end
      default: packedErr = 1'b1;
    endcase
  end

  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Err_d    = s1Err_q;
    s1Word_d   = s1Word_q;
    s2Valid_d  = s2Valid_q;
    s2Err_d    = s2Err_q;
    s2Word_d   = s2Word_q;
    addr_d     = addr_q;
    errCount_d = errCount_q;
    if (inReady) begin
      s1Valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1Word_d = packedErr ? NOP : packedWord;
        s1Err_d  = packedErr;
      end
    end
    if (s2Advance) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Word_d = s1Word_q;
        s2Err_d  = s1Err_q;
      end
    end
    // The address belongs to the word currently presented, so it steps after it leaves.
    if (outXfer) begin
      addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
      if (s2Err_q && !(&errCount_q)) begin
        errCount_d = errCount_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1Valid_q  <= 1'b0;
      s1Err_q    <= 1'b0;
      s1Word_q   <= '0;
      s2Valid_q  <= 1'b0;
      s2Err_q    <= 1'b0;
      s2Word_q   <= '0;
      addr_q     <= '0;
      errCount_q <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Err_q    <= s1Err_d;
      s1Word_q   <= s1Word_d;
      s2Valid_q  <= s2Valid_d;
      s2Err_q    <= s2Err_d;
      s2Word_q   <= s2Word_d;
      addr_q     <= addr_d;
      errCount_q <= errCount_d;
    end
  end

  assign bus.in_ready        = inReady;
  assign bus.out_valid       = s2Valid_q;
  assign bus.out_instruction = s2Word_q;
  assign bus.out_address     = addr_q;
  assign bus.out_error       = s2Err_q;
  assign bus.error_count     = errCount_q;
endmodule

// File: tb/tb_encode_instruction.sv
// Scoreboard bench for encode_instruction: small DEPTH and COUNT_WIDTH so that
// address wrap and error-count saturation are reachable in a short run.
`timescale 1ns/1ps
module tb_encode_instruction;
  localparam int DEPTH       = 4;
  localparam int ADDR_WIDTH  = 8;
  localparam int COUNT_WIDTH = 3;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0]           word;
    logic                  err;
    logic [ADDR_WIDTH-1:0] addr;
  } exp_t;

  typedef struct {
    bit                     acc;
    bit                     xfer;
    logic                   rdy;
    logic                   vld;
    logic [31:0]            word;
    logic                   err;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [COUNT_WIDTH-1:0] cnt;
  } obs_t;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  encode_instruction_if #(.ADDR_WIDTH(ADDR_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) bus ();

  encode_instruction #(
    .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  function automatic req_t mkReq(input logic [2:0] fmt, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  function automatic req_t randReq();
    req_t r;
    r.fmt = 3'($urandom_range(0, 7));
    r.op  = 7'($urandom);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    r.f3  = 3'($urandom);
    r.f7  = 7'($urandom);
    case ($urandom_range(0, 3))
      0:       r.imm = $urandom;
      1:       r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       r.imm = $urandom & 32'hFFFF_F000;
      default: r.imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
    endcase
    return r;
  endfunction

  // Reference encoder built from masks, shifts and signed range tests.
  function automatic void model(input req_t r, output logic [31:0] w, output logic e);
    logic [31:0] imm, op, rd, rs1, rs2, f3, f7;
    int   s;
    logic ok;
    imm = r.imm; op = 32'(r.op); rd = 32'(r.rd); rs1 = 32'(r.rs1);
    rs2 = 32'(r.rs2); f3 = 32'(r.f3); f7 = 32'(r.f7);
    s  = int'(imm);
    ok = 1'b1;
    w  = '0;
    case (r.fmt)
      3'd0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      3'd2: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
           | ((imm & 32'h1F) << 7) | op;
      end
      3'd3: begin
        ok = (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
        w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
           | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
           | (((imm >> 11) & 32'h1) << 7) | op;
      end
      3'd4: begin
        ok = (imm & 32'hFFF) == 32'h0;
        w  = (imm & 32'hFFFF_F000) | (rd << 7) | op;
      end
      3'd5: begin
        ok = (s >= -1048576) && (s <= 1048575) && (imm[0] == 1'b0);
        w  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
           | (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000F_F000) | (rd << 7) | op;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) w = 32'h0000_0013;
    e = !ok;
  endfunction

  task automatic driveReq(input req_t r);
    bus.in_format    = r.fmt;
    bus.in_opcode    = r.op;
    bus.in_rd        = r.rd;
    bus.in_rs1       = r.rs1;
    bus.in_rs2       = r.rs2;
    bus.in_funct3    = r.f3;
    bus.in_funct7    = r.f7;
    bus.in_immediate = r.imm;
  endtask

  // One clock: sample handshakes on the falling edge, return at rising edge + 1.
  task automatic step(output obs_t o);
    @(negedge clock);
    o.acc  = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
    o.xfer = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
    o.rdy  = bus.in_ready;
    o.vld  = bus.out_valid;
    o.word = bus.out_instruction;
    o.err  = bus.out_error;
    o.addr = bus.out_address;
    o.cnt  = bus.error_count;
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    driveReq(mkReq(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    driveReq(mkReq(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_instruction !== 32'h0 || bus.out_address !== '0
        || bus.out_error !== 1'b0 || bus.error_count !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got v=%b w=%h a=%0d e=%b c=%0d, expected all zero",
               bus.out_valid, bus.out_instruction, bus.out_address, bus.out_error, bus.error_count);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_latency();
    obs_t o;
    doReset();
    driveReq(mkReq(1, 7'b0010011, 1, 0, 9, 0, 7'h7F, 32'd5));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step(o);
    bus.in_valid = 1'b0;
    checks++;
    if (!o.acc) begin
      failures++;
      $display("[TB] FAIL latency_accept: got acc=%b expected 1", o.acc);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL latency_early: got out_valid=%b one cycle after accept, expected 0",
               bus.out_valid);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instruction !== 32'h0050_0093
        || bus.out_address !== '0 || bus.out_error !== 1'b0) begin
      failures++;
      $display("[TB] FAIL latency_output: got v=%b w=%h a=%0d e=%b, expected v=1 w=00500093 a=0 e=0",
               bus.out_valid, bus.out_instruction, bus.out_address, bus.out_error);
    end
    step(o);
  endtask

  task automatic test_directed();
    req_t        reqs[$];
    logic [31:0] expWords[$];
    exp_t        e;
    obs_t        o;
    int          idx = 0, cycles = 0, nextAddr = 0;
    doReset();
    reqs.push_back(mkReq(1, 7'b0010011, 1, 0, 9, 0, 7'h7F, 32'd5));       expWords.push_back(32'h0050_0093);
    reqs.push_back(mkReq(3, 7'b1100011, 31, 0, 0, 0, 7'h55, -32'sd8));    expWords.push_back(32'hFE00_0CE3);
    reqs.push_back(mkReq(5, 7'b1101111, 1, 7, 3, 5, 7'h11, 32'h800));     expWords.push_back(32'h0010_00EF);
    reqs.push_back(mkReq(0, 7'b0110011, 3, 1, 2, 0, 0, 32'hDEAD_BEEF));   expWords.push_back(32'h0020_81B3);
    reqs.push_back(mkReq(4, 7'b0110111, 5, 31, 31, 7, 7'h7F, 32'h1234_5000)); expWords.push_back(32'h1234_52B7);
    bus.out_ready = 1'b1;
    while ((idx < reqs.size() || sb.size() != 0) && cycles < 30) begin
      if (idx < reqs.size()) begin
        driveReq(reqs[idx]);
        bus.in_valid = 1'b1;
      end else bus.in_valid = 1'b0;
      step(o);
      cycles++;
      if (o.xfer) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL directed_extra: got word %h with nothing expected", o.word);
        end else begin
          e = sb.pop_front();
          if (o.word !== e.word || o.err !== e.err || o.addr !== e.addr) begin
            failures++;
            $display("[TB] FAIL directed_word: got w=%h e=%b a=%0d expected w=%h e=%b a=%0d",
                     o.word, o.err, o.addr, e.word, e.err, e.addr);
          end
        end
      end
      if (o.acc) begin
        sb.push_back('{expWords[idx], 1'b0, ADDR_WIDTH'(nextAddr)});
        idx++;
        nextAddr = (nextAddr == DEPTH - 1) ? 0 : nextAddr + 1;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (cycles != reqs.size() + 2 || sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL directed_throughput: got %0d cycles left=%0d expected %0d cycles left=0",
               cycles, sb.size(), reqs.size() + 2);
    end
  endtask

  task automatic test_errors();
    req_t reqs[$];
    exp_t e;
    obs_t o;
    int   idx = 0, cycles = 0, nextAddr = 0, errOut = 0;
    doReset();
    reqs.push_back(mkReq(1, 7'b0010011, 1, 2, 0, 0, 0, 32'd4096));
    reqs.push_back(mkReq(3, 7'b1100011, 0, 1, 2, 0, 0, 32'd7));
    reqs.push_back(mkReq(4, 7'b0110111, 5, 0, 0, 0, 0, 32'h0000_0001));
    reqs.push_back(mkReq(6, 7'b0010011, 1, 0, 0, 0, 0, 32'd0));
    reqs.push_back(mkReq(5, 7'b1101111, 1, 0, 0, 0, 0, 32'd3));
    reqs.push_back(mkReq(2, 7'b0100011, 0, 1, 2, 2, 0, -32'sd2049));
    reqs.push_back(mkReq(7, 7'b0110011, 1, 1, 1, 0, 0, 32'd0));
    reqs.push_back(mkReq(1, 7'b0010011, 1, 0, 0, 0, 0, 32'h8000_0000));
    bus.out_ready = 1'b1;
    while ((idx < reqs.size() || sb.size() != 0) && cycles < 40) begin
      if (idx < reqs.size()) begin
        driveReq(reqs[idx]);
        bus.in_valid = 1'b1;
      end else bus.in_valid = 1'b0;
      step(o);
      cycles++;
      if (o.xfer) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL errors_extra: got word %h with nothing expected", o.word);
        end else begin
          e = sb.pop_front();
          if (o.word !== e.word || o.err !== e.err || o.addr !== e.addr
              || o.cnt !== COUNT_WIDTH'((errOut > 7) ? 7 : errOut)) begin
            failures++;
            $display("[TB] FAIL errors_word: got w=%h e=%b a=%0d cnt=%0d expected w=%h e=%b a=%0d cnt=%0d",
                     o.word, o.err, o.addr, o.cnt, e.word, e.err, e.addr, (errOut > 7) ? 7 : errOut);
          end
        end
        errOut++;
      end
      if (o.acc) begin
        sb.push_back('{32'h0000_0013, 1'b1, ADDR_WIDTH'(nextAddr)});
        idx++;
        nextAddr = (nextAddr == DEPTH - 1) ? 0 : nextAddr + 1;
      end
    end
    bus.in_valid = 1'b0;
    step(o);
    checks++;
    if (o.cnt !== 3'd7 || errOut != 8) begin
      failures++;
      $display("[TB] FAIL errors_saturate: got count=%0d outputs=%0d expected count=7 outputs=8",
               o.cnt, errOut);
    end
  endtask

  task automatic test_backpressure();
    req_t        reqs[$];
    exp_t        e;
    obs_t        o;
    logic [31:0] w;
    logic        er;
    int          idx = 0, cycles = 0, nextAddr = 0;
    doReset();
    reqs.push_back(mkReq(1, 7'b0010011, 4, 3, 0, 0, 0, -32'sd1));
    reqs.push_back(mkReq(2, 7'b0100011, 0, 2, 8, 2, 0, 32'd100));
    reqs.push_back(mkReq(3, 7'b1100011, 0, 5, 6, 1, 0, 32'd4094));
    reqs.push_back(mkReq(4, 7'b0010111, 9, 0, 0, 0, 0, 32'hFFFF_F000));
    while ((idx < reqs.size() || sb.size() != 0) && cycles < 30) begin
      if (idx < reqs.size()) begin
        driveReq(reqs[idx]);
        bus.in_valid = 1'b1;
      end else bus.in_valid = 1'b0;
      bus.out_ready = (cycles >= 6);
      step(o);
      if (cycles >= 2 && cycles <= 5) begin
        checks++;
        if (o.rdy !== 1'b0 || o.vld !== 1'b1 || sb.size() == 0 || idx != 2
            || (sb.size() != 0 && o.word !== sb[0].word)) begin
          failures++;
          $display("[TB] FAIL backpressure_hold: cycle %0d got rdy=%b vld=%b w=%h accepted=%0d expected rdy=0 vld=1 accepted=2",
                   cycles, o.rdy, o.vld, o.word, idx);
        end
      end
      cycles++;
      if (o.xfer) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL backpressure_extra: got word %h with nothing expected", o.word);
        end else begin
          e = sb.pop_front();
          if (o.word !== e.word || o.err !== e.err || o.addr !== e.addr) begin
            failures++;
            $display("[TB] FAIL backpressure_word: got w=%h e=%b a=%0d expected w=%h e=%b a=%0d",
                     o.word, o.err, o.addr, e.word, e.err, e.addr);
          end
        end
      end
      if (o.acc) begin
        model(reqs[idx], w, er);
        sb.push_back('{w, er, ADDR_WIDTH'(nextAddr)});
        idx++;
        nextAddr = (nextAddr == DEPTH - 1) ? 0 : nextAddr + 1;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (idx != 4 || sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL backpressure_drain: got accepted=%0d left=%0d expected accepted=4 left=0",
               idx, sb.size());
    end
  endtask

  task automatic test_wrap_random();
    req_t        r;
    exp_t        e;
    obs_t        o;
    logic [31:0] w;
    logic        er;
    int          idx = 0, cycles = 0, nextAddr = 0, nOut = 0, wrapBad = 0;
    bit          offering = 1'b0;
    localparam int N = 24;
    doReset();
    while ((idx < N || sb.size() != 0) && cycles < 400) begin
      if (!offering && idx < N && $urandom_range(0, 3) != 0) begin
        r = randReq();
        driveReq(r);
        offering = 1'b1;
      end
      bus.in_valid  = offering;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step(o);
      cycles++;
      if (o.xfer) begin
        checks++;
        if (nOut < 6 && o.addr !== ADDR_WIDTH'(nOut % DEPTH)) wrapBad++;
        nOut++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL random_extra: got word %h with nothing expected", o.word);
        end else begin
          e = sb.pop_front();
          if (o.word !== e.word || o.err !== e.err || o.addr !== e.addr) begin
            failures++;
            $display("[TB] FAIL random_word: got w=%h e=%b a=%0d expected w=%h e=%b a=%0d",
                     o.word, o.err, o.addr, e.word, e.err, e.addr);
          end
        end
      end
      if (o.acc) begin
        model(r, w, er);
        sb.push_back('{w, er, ADDR_WIDTH'(nextAddr)});
        idx++;
        offering = 1'b0;
        nextAddr = (nextAddr == DEPTH - 1) ? 0 : nextAddr + 1;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (wrapBad != 0 || nOut != N || sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL wrap_sequence: got bad=%0d outputs=%0d left=%0d expected bad=0 outputs=%0d left=0",
               wrapBad, nOut, sb.size(), N);
    end
  endtask

  task automatic test_reset_midstream();
    obs_t o;
    int   n, accepted;
    doReset();
    driveReq(mkReq(3, 7'b1100011, 0, 0, 0, 0, 0, 32'd7));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step(o);
    bus.in_valid = 1'b0;
    n = 0;
    while (!o.xfer && n < 10) begin
      step(o);
      n++;
    end
    bus.out_ready = 1'b0;
    accepted = 0;
    n = 0;
    while (accepted < 2 && n < 10) begin
      if (accepted == 0) driveReq(mkReq(0, 7'b0110011, 3, 1, 2, 0, 0, 32'd0));
      else               driveReq(mkReq(1, 7'b0010011, 2, 2, 0, 0, 0, 32'd9));
      bus.in_valid = 1'b1;
      step(o);
      if (o.acc) accepted++;
      n++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.error_count !== 3'd1
        || bus.out_address !== 8'd1) begin
      failures++;
      $display("[TB] FAIL midstream_full: got v=%b rdy=%b cnt=%0d a=%0d expected v=1 rdy=0 cnt=1 a=1",
               bus.out_valid, bus.in_ready, bus.error_count, bus.out_address);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_instruction !== 32'h0 || bus.out_address !== '0
        || bus.out_error !== 1'b0 || bus.error_count !== '0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midstream_async: got v=%b w=%h a=%0d e=%b cnt=%0d rdy=%b expected zeros and rdy=1",
               bus.out_valid, bus.out_instruction, bus.out_address, bus.out_error,
               bus.error_count, bus.in_ready);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    driveReq(mkReq(1, 7'b0010011, 1, 0, 0, 0, 0, 32'd5));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step(o);
    bus.in_valid = 1'b0;
    n = 0;
    while (!o.xfer && n < 10) begin
      step(o);
      n++;
    end
    checks++;
    if (!o.xfer || o.word !== 32'h0050_0093 || o.addr !== '0 || o.err !== 1'b0 || o.cnt !== '0) begin
      failures++;
      $display("[TB] FAIL midstream_restart: got x=%b w=%h a=%0d e=%b cnt=%0d expected x=1 w=00500093 a=0 e=0 cnt=0",
               o.xfer, o.word, o.addr, o.err, o.cnt);
    end
  endtask

  initial begin
    $display("[TB] encode_instruction bench start");
    test_reset();
    test_latency();
    test_directed();
    test_errors();
    test_backpressure();
    test_wrap_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
